// File: rtl/ct_fcnvt_pkg.sv
// Shared types and helpers for the vector floating-point convert sequencer.
package ct_fcnvt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } fcnvt_state_e;

    // Bit positions inside the 5-bit fflags vector {NV,DZ,OF,UF,NX}.
    typedef enum int {
        FFLAG_NX = 0,
        FFLAG_UF = 1,
        FFLAG_OF = 2,
        FFLAG_DZ = 3,
        FFLAG_NV = 4
    } fflag_pos_e;

    localparam int FFLAGS_W = 5;

    // Lane index width; a single-lane build still needs a 1-bit index.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/ct_fcnvt_lane_pick.sv
// Lowest-set-bit priority encoder: selects the next lane to issue.
module ct_fcnvt_lane_pick #(
    parameter int LANES = 4,
    parameter int IDX_W = 2
) (
    input  logic [LANES-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic [LANES-1:0] onehot,
    output logic             any
);

    always_comb begin
        idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
        onehot = mask & (~mask + LANES'(1));
        any    = |mask;
    end

endmodule

// File: rtl/ct_fcnvt_vec_seq.sv
// Vector lane sequencer: issues enabled lanes one per cycle into the scalar
// convert datapath and assembles the vector result and OR-ed fflags.
module ct_fcnvt_vec_seq
    import ct_fcnvt_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int ELEN   = 64,
    parameter int LAT    = 3,
    parameter int FUNC_W = 20
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst,
    input  logic                    req_vld,
    output logic                    req_rdy,
    input  logic [LANES*ELEN-1:0]   req_src,
    input  logic [LANES*ELEN-1:0]   req_old,
    input  logic [LANES-1:0]        req_mask,
    input  logic [FUNC_W-1:0]       req_func,
    input  logic [2:0]              req_rm,
    input  logic                    flush,
    output logic                    core_ex1_vld,
    output logic [ELEN-1:0]         core_ex1_src,
    output logic [FUNC_W-1:0]       core_ex1_func,
    output logic [2:0]              core_ex1_rm,
    input  logic                    core_ex3_vld,
    input  logic [ELEN-1:0]         core_ex3_result,
    input  logic [FFLAGS_W-1:0]     core_ex3_expt,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [LANES*ELEN-1:0]   out_result,
    output logic [FFLAGS_W-1:0]     out_expt
);

    localparam int LANE_IDX_W = lane_idx_w(LANES);
    localparam int VEC_W      = LANES * ELEN;

    fcnvt_state_e state_q, state_d;
    logic [VEC_W-1:0]    src_q, src_d;
    logic [VEC_W-1:0]    res_q, res_d;
    logic [LANES-1:0]    rem_q, rem_d;
    logic [FUNC_W-1:0]   func_q, func_d;
    logic [2:0]          rm_q, rm_d;
    logic [FFLAGS_W-1:0] expt_q, expt_d;
    logic                out_vld_q, out_vld_d;
    logic [LAT-1:0]                  tag_vld_q, tag_vld_d;
    logic [LAT-1:0][LANE_IDX_W-1:0]  tag_idx_q, tag_idx_d;

    logic [LANE_IDX_W-1:0] pick_idx;
    logic [LANES-1:0]      pick_oh;
    logic                  pick_any;
    logic                  issue;
    logic                  collect;
    logic                  tags_drained;

    ct_fcnvt_lane_pick #(
        .LANES (LANES),
        .IDX_W (LANE_IDX_W)
    ) u_lane_pick (
        .mask   (rem_q),
        .idx    (pick_idx),
        .onehot (pick_oh),
        .any    (pick_any)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        res_d   = res_q;
        rem_d   = rem_q;
        func_d  = func_q;
        rm_d    = rm_q;
        expt_d  = expt_q;

        issue = (state_q == ST_ISSUE) && pick_any;

        // Tag pipeline mirrors the datapath latency; the tail lines up with ex3.
        tag_vld_d[0] = issue;
        tag_idx_d[0] = pick_idx;
        for (int i = 1; i < LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end

        // True when nothing will be in flight after this edge.
        tags_drained = ~issue;
        for (int i = 0; i < LAT - 1; i++) begin
            if (tag_vld_q[i]) begin
                tags_drained = 1'b0;
            end
        end

        collect = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && !flush
                  && tag_vld_q[LAT-1];
        if (collect) begin
            res_d[tag_idx_q[LAT-1]*ELEN +: ELEN] = core_ex3_result;
            expt_d = expt_q | core_ex3_expt;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    src_d   = req_src;
                    res_d   = req_old;
                    rem_d   = req_mask;
                    func_d  = req_func;
                    rm_d    = req_rm;
                    expt_d  = '0;
                    state_d = (req_mask == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rem_d = rem_q & ~pick_oh;
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (rem_d == '0) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (tags_drained) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || out_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (tags_drained) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        out_vld_d = (state_d == ST_DONE);
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            res_q     <= '0;
            rem_q     <= '0;
            func_q    <= '0;
            rm_q      <= '0;
            expt_q    <= '0;
            out_vld_q <= 1'b0;
            tag_vld_q <= '0;
            tag_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            res_q     <= res_d;
            rem_q     <= rem_d;
            func_q    <= func_d;
            rm_q      <= rm_d;
            expt_q    <= expt_d;
            out_vld_q <= out_vld_d;
            tag_vld_q <= tag_vld_d;
            tag_idx_q <= tag_idx_d;
        end
    end

    assign req_rdy       = (state_q == ST_IDLE);
    assign core_ex1_vld  = issue;
    assign core_ex1_src  = issue ? src_q[pick_idx*ELEN +: ELEN] : '0;
    assign core_ex1_func = issue ? func_q : '0;
    assign core_ex1_rm   = issue ? rm_q : '0;
    assign out_vld       = out_vld_q;
    assign out_result    = res_q;
    assign out_expt      = expt_q;

    // The datapath must return exactly when a tag reaches the tail.
    tag_return_check: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) |-> (core_ex3_vld == tag_vld_q[LAT-1]));

endmodule

// File: doc/ct_fcnvt_vec_seq.md
# ct_fcnvt_vec_seq

Vector lane sequencer for the floating-point convert path. It accepts one vector convert request of `LANES` elements and issues the active lanes, one per cycle, into the existing fixed-latency scalar convert datapath. It collects the lane results into a result vector, merges them with the old destination for masked-off lanes, and ORs the per-lane exception flags. It sits between VFALU dispatch and the scalar convert datapath, replacing the scalar-only top level.

## Interface
Parameters:
- `LANES`, 4: number of vector elements per request.
- `ELEN`, 64: element width in bits.
- `LAT`, 3: scalar datapath latency, issue cycle to result cycle; ≥1.
- `FUNC_W`, 20: width of the function code.

Ports:
- `forever_cpuclk` in 1: clock.
- `cpurst` in 1: reset, synchronous, active-high.
- `req_vld` in 1: request valid.
- `req_rdy` out 1: request ready.
- `req_src` in LANES*ELEN: source elements; lane i is at [i*ELEN +: ELEN].
- `req_old` in LANES*ELEN: old destination value, used for masked lanes.
- `req_mask` in LANES: lane enable.
- `req_func` in FUNC_W: convert function code.
- `req_rm` in 3: rounding mode.
- `flush` in 1: kill the current request.
- `core_ex1_vld` out 1: lane issue strobe.
- `core_ex1_src` out ELEN: lane source.
- `core_ex1_func` out FUNC_W: function code.
- `core_ex1_rm` out 3: rounding mode.
- `core_ex3_vld` in 1: lane result valid, LAT cycles after issue.
- `core_ex3_result` in ELEN: lane result.
- `core_ex3_expt` in 5: lane fflags {NV,DZ,OF,UF,NX}.
- `out_vld` out 1: vector result valid.
- `out_rdy` in 1: consumer ready.
- `out_result` out LANES*ELEN: vector result.
- `out_expt` out 5: OR of fflags over the enabled lanes.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- **IDLE**:
  - `req_rdy`=1.
  - On `req_vld`, capture src, old, mask, func, and rm.
  - Preload the result register with `req_old`. Clear the expt accumulator.
  - Set the remaining mask to `req_mask`.
  - Go to ISSUE, or to DONE if the mask is all zero.
- **ISSUE**:
  - Each cycle, pick the lowest set bit of the remaining mask.
  - Drive `core_ex1_vld`=1 with that lane's src, func, and rm, then clear the bit.
  - Push {vld, lane index} into a LAT-deep tag shift register.
  - When the last bit is issued, go to WAIT.
- **Return** (in ISSUE or WAIT):
  - When the tail tag is valid, write `core_ex3_result` to that lane of the result register.
  - OR `core_ex3_expt` into the accumulator.
  - `core_ex3_vld` must equal the tail-tag valid; a mismatch is an assertion failure.
- **WAIT**: go to DONE the cycle after the last outstanding tag retires.
- **DONE**:
  - `out_vld`=1. `out_result` and `out_expt` are held stable until `out_rdy`.
  - On `out_rdy`, go to IDLE.
  - No back-to-back acceptance in the same cycle: `req_rdy`=0 in DONE.
- **flush**:
  - From ISSUE or WAIT, stop issuing immediately. A flush in the issue cycle still issues that lane, because the core has already sampled it.
  - Go to DRAIN. Returning tags are discarded and do not update the result or expt.
  - Leave DRAIN the cycle the tag register is empty.
  - A flush in DONE drops `out_vld` and goes to IDLE.
  - A flush in IDLE or DRAIN is ignored.
- **Reset** (applies mid-operation too): state=IDLE and all tags invalid. All outputs are 0 except `req_rdy`=1. `out_result` and `out_expt` are 0.

## Timing
- The request is accepted at cycle T.
- With k enabled lanes, the issues occur at T+1 … T+k.
- The returns occur at T+1+LAT … T+k+LAT.
- `out_vld` first rises at T+k+LAT+1.
- With k=0, `out_vld` rises at T+1.
- Throughput: 1 lane per cycle. No request overlap.
- `core_ex1_*` outputs are registered or state-derived only; they have no combinational path from `req_*`.
- `out_*` outputs are registered.

## Structure
- Shared package `ct_fcnvt_pkg`:
  - state enum;
  - fflags bit positions;
  - `LANE_IDX_W = $clog2(LANES)`, with a minimum of 1.
- One natural sub-module: `ct_fcnvt_lane_pick`, a combinational lowest-set-bit priority encoder producing index and one-hot.
- The tag shift register and the result register are inline.

## Test plan
- LANES=4, LAT=3, mask=4'b1111, lanes return results A0..A3 with expt 0:
  - issue strobes on 4 consecutive cycles;
  - `out_vld` at T+8 with result {A3,A2,A1,A0}.
- mask=4'b0101, old={O3,O2,O1,O0}, lane0 expt=5'b00001, lane2 expt=5'b10000:
  - only lanes 0 and 2 are issued;
  - `out_result`={O3,R2,O1,R0}, `out_expt`=5'b10001, `out_vld` at T+6.
- mask=0:
  - no `core_ex1_vld`;
  - `out_vld` at T+1 with result = old and expt=0.
- `out_rdy` held 0 for 5 cycles in DONE:
  - outputs stable;
  - `req_rdy`=0 throughout;
  - IDLE on the cycle after `out_rdy`=1.
- flush at the 2nd issue cycle with mask=1111:
  - exactly 2 lanes issued;
  - their returns are ignored;
  - `req_rdy` returns only after the tags drain (T+2+LAT+1);
  - the next request is unaffected.
- cpurst asserted during WAIT:
  - next cycle, all outputs 0 and `req_rdy`=1;
  - late `core_ex3_vld` pulses are ignored.
